// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: output-mode encodings
// and the parameter legality check used at elaboration.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic bit fifo_params_ok(input int asize, input int afull_th,
                                          input int aempty_th, input int fwft);
        int depth;
        if (asize < 1 || asize > 30) return 1'b0;
        depth = 1 << asize;
        if (afull_th < 1 || afull_th > depth) return 1'b0;
        if (aempty_th < 0 || aempty_th > depth - 1) return 1'b0;
        if (fwft != FIFO_STD && fwft != FIFO_FWFT) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DSIZE register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo2.sv
// Single-clock FIFO with registered occupancy count, almost-full/empty
// thresholds, sticky error flags, synchronous flush and selectable FWFT output.
module sync_fifo2
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    if (!fifo_params_ok(ASIZE, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_bad_params
        $error("sync_fifo2: illegal parameter combination");
    end

    localparam logic [ASIZE:0] PTR_ONE  = {{ASIZE{1'b0}}, 1'b1};
    localparam logic [ASIZE:0] DEPTH_C  = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] AFULL_C  = AFULL_TH[ASIZE:0];
    localparam logic [ASIZE:0] AEMPTY_C = AEMPTY_TH[ASIZE:0];

    logic [ASIZE:0]   r_wptr;
    logic [ASIZE:0]   r_rptr;
    logic [ASIZE:0]   r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_wacc;
    logic             w_racc;
    logic [DSIZE-1:0] w_mem_rdata;

    // Flags decode only the registered count, so no path from winc/rinc.
    assign wfull         = (r_count == DEPTH_C);
    assign rempty        = (r_count == '0);
    assign walmost_full  = (r_count >= AFULL_C);
    assign ralmost_empty = (r_count <= AEMPTY_C);
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

    assign w_wacc = winc && !wfull && !clr;
    assign w_racc = rinc && !rempty && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wacc) r_wptr <= r_wptr + PTR_ONE;
            if (w_racc) r_rptr <= r_rptr + PTR_ONE;
            if (w_wacc && !w_racc) r_count <= r_count + PTR_ONE;
            else if (w_racc && !w_wacc) r_count <= r_count - PTR_ONE;
            if (winc && wfull) r_overflow <= 1'b1;
            if (rinc && rempty) r_underflow <= 1'b1;
        end
    end

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wacc),
        .i_waddr (r_wptr[ASIZE-1:0]),
        .i_wdata (wdata),
        .i_raddr (r_rptr[ASIZE-1:0]),
        .o_rdata (w_mem_rdata)
    );

    if (FWFT == FIFO_STD) begin : g_std
        logic [DSIZE-1:0] r_rdata;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)      r_rdata <= '0;
            else if (clr)    r_rdata <= '0;
            else if (w_racc) r_rdata <= w_mem_rdata;
        end

        assign rdata = r_rdata;
    end else begin : g_fwft
        assign rdata = w_mem_rdata;
    end

endmodule

// File: tb/tb_sync_fifo2.sv
// Bench for sync_fifo2: a standard and an FWFT instance share one stimulus
// stream and are compared each cycle against a queue-based reference model.
module tb_sync_fifo2;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       winc;
    logic       rinc;
    logic [7:0] wdata;

    logic       s_wfull, s_walmost_full, s_rempty, s_ralmost_empty, s_overflow, s_underflow;
    logic [7:0] s_rdata;
    logic [4:0] s_count;
    logic       f_wfull, f_walmost_full, f_rempty, f_ralmost_empty, f_overflow, f_underflow;
    logic [7:0] f_rdata;
    logic [4:0] f_count;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_udf;
    logic [7:0] m_rd;

    sync_fifo2 #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(clr), .winc(winc), .wdata(wdata),
        .wfull(s_wfull), .walmost_full(s_walmost_full), .rinc(rinc), .rdata(s_rdata),
        .rempty(s_rempty), .ralmost_empty(s_ralmost_empty), .count(s_count),
        .overflow(s_overflow), .underflow(s_underflow)
    );

    sync_fifo2 #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .winc(winc), .wdata(wdata),
        .wfull(f_wfull), .walmost_full(f_walmost_full), .rinc(rinc), .rdata(f_rdata),
        .rempty(f_rempty), .ralmost_empty(f_ralmost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_rd  = 8'h00;
    endtask

    task automatic model_edge(input logic w, input logic r, input logic c, input logic [7:0] d);
        int n;
        n = q.size();
        if (c) begin
            model_reset();
        end else begin
            if (w && n == 16) m_ovf = 1'b1;
            if (r && n == 0)  m_udf = 1'b1;
            if (r && n > 0)   m_rd = q.pop_front();
            if (w && n < 16)  q.push_back(d);
        end
    endtask

    task automatic check_outputs(input string ph);
        int n;
        n = q.size();
        check({ph, ":count_std"},  32'(s_count), n);
        check({ph, ":count_fwft"}, 32'(f_count), n);
        check({ph, ":wfull_std"},  32'(s_wfull), 32'(n == 16));
        check({ph, ":wfull_fwft"}, 32'(f_wfull), 32'(n == 16));
        check({ph, ":rempty_std"}, 32'(s_rempty), 32'(n == 0));
        check({ph, ":rempty_fwft"}, 32'(f_rempty), 32'(n == 0));
        check({ph, ":afull_std"},  32'(s_walmost_full), 32'(n >= 12));
        check({ph, ":afull_fwft"}, 32'(f_walmost_full), 32'(n >= 12));
        check({ph, ":aempty_std"}, 32'(s_ralmost_empty), 32'(n <= 2));
        check({ph, ":aempty_fwft"}, 32'(f_ralmost_empty), 32'(n <= 2));
        check({ph, ":ovf_std"},    32'(s_overflow), 32'(m_ovf));
        check({ph, ":ovf_fwft"},   32'(f_overflow), 32'(m_ovf));
        check({ph, ":udf_std"},    32'(s_underflow), 32'(m_udf));
        check({ph, ":udf_fwft"},   32'(f_underflow), 32'(m_udf));
        check({ph, ":rdata_std"},  32'(s_rdata), 32'(m_rd));
        if (n > 0) check({ph, ":rdata_fwft"}, 32'(f_rdata), 32'(q[0]));
    endtask

    task automatic step(input string ph, input logic w, input logic r, input logic c,
                        input logic [7:0] d);
        winc  = w;
        rinc  = r;
        clr   = c;
        wdata = d;
        @(posedge clk);
        model_edge(w, r, c, d);
        #1;
        check_outputs(ph);
    endtask

    task automatic goto_count(input string ph, input int target);
        while (q.size() < target) step(ph, 1'b1, 1'b0, 1'b0, 8'($urandom));
        while (q.size() > target) step(ph, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = 8'h00;
        model_reset();
        #3;
        check_outputs("reset");
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_reset");

        for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 1'b0, 8'(i));
        step("fill_ovf", 1'b1, 1'b0, 1'b0, 8'hEE);

        for (int i = 0; i < 16; i++) step("drain", 1'b0, 1'b1, 1'b0, 8'h00);
        step("drain_udf", 1'b0, 1'b1, 1'b0, 8'h00);

        step("fwft_wr", 1'b1, 1'b0, 1'b0, 8'hA5);
        step("fwft_idle", 1'b0, 1'b0, 1'b0, 8'h00);
        step("fwft_pop", 1'b0, 1'b1, 1'b0, 8'h00);

        goto_count("to8", 8);
        step("rw_at8", 1'b1, 1'b1, 1'b0, 8'h3C);
        goto_count("to16", 16);
        step("rw_at16", 1'b1, 1'b1, 1'b0, 8'h5A);
        goto_count("to0", 0);
        step("rw_at0", 1'b1, 1'b1, 1'b0, 8'h69);

        goto_count("to4", 4);
        for (int i = 0; i < 100; i++) begin
            logic w, r;
            w = (q.size() < 5) && ($urandom_range(3) != 0);
            r = (q.size() > 3) && ($urandom_range(3) != 0);
            step("wrap", w, r, 1'b0, 8'($urandom));
        end

        goto_count("to10", 10);
        step("to10_ovf", 1'b1, 1'b1, 1'b0, 8'h00);
        step("clr_wr", 1'b1, 1'b0, 1'b1, 8'h77);

        for (int i = 0; i < 200; i++) begin
            if (i == 120) begin
                winc  = 1'b1;
                rinc  = 1'b1;
                wdata = 8'hC3;
                rst_n = 1'b0;
                #2;
                model_reset();
                check_outputs("async_rst");
                #2;
                rst_n = 1'b1;
            end
            step("rand", 1'($urandom), 1'($urandom), ($urandom_range(31) == 0), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
